// File: rtl/axi4_lite_gpio_if.sv
// AXI4-Lite bus bundle shared by the GPIO block and its masters.
// aclk/aresetn travel with the bus but the GPIO slave clocks from its own ports.
interface axi4_lite_if #(
  parameter int ALEN = 32,
  parameter int DLEN = 32
);
  logic              aclk;
  logic              aresetn;
  logic [ALEN-1:0]   awaddr;
  logic              awvalid;
  logic              awready;
  logic [DLEN-1:0]   wdata;
  logic [DLEN/8-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ALEN-1:0]   araddr;
  logic              arvalid;
  logic              arready;
  logic [DLEN-1:0]   rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport S (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport M (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_gpio.sv
// AXI4-Lite GPIO: LED register, synchronized switches/buttons, button edge capture with irq.
// Define GPIO_DEBOUNCE_EN to add per-input debounce counters (window DB_CYCLES).
module axi4_lite_gpio #(
  parameter int ALEN      = 32,
  parameter int NUM_LED   = 8,
  parameter int NUM_SW    = 8,
  parameter int NUM_BTN   = 5,
  parameter int DB_CYCLES = 1000000
) (
  input  logic               aclk,
  input  logic               areset,
  axi4_lite_if.S             s_axi,
  output logic [NUM_LED-1:0] led,
  input  logic [NUM_SW-1:0]  sw,
  input  logic [NUM_BTN-1:0] btn,
  output logic               irq
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HAVE_AW = 2'd1;
  localparam logic [1:0] ST_HAVE_W  = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int NI = NUM_SW + NUM_BTN;

  logic [1:0]         wstate;
  logic               en_q;
  logic [ALEN-1:0]    aw_addr_q;
  logic [31:0]        w_data_q;
  logic [3:0]         w_strb_q;
  logic [1:0]         bresp_q;
  logic               rvalid_q;
  logic [31:0]        rdata_q;
  logic [1:0]         rresp_q;
  logic [NUM_LED-1:0] led_q;
  logic [NUM_BTN-1:0] edge_q, edge_next, btn_prev, edge_clr;
  logic               irq_q;
  logic [NI-1:0]      sync1, sync2, cond;
  logic [NUM_SW-1:0]  sw_c;
  logic [NUM_BTN-1:0] btn_c;

  logic            aw_hs, w_hs, ar_hs, wr_go, wr_mapped, rd_mapped;
  logic [ALEN-1:0] wr_addr;
  logic [31:0]     wr_data, lane_mask, rd_word;
  logic [3:0]      wr_strb;

  // Readies stay low until the first edge after reset releases.
  assign s_axi.awready = en_q && (wstate == ST_IDLE || wstate == ST_HAVE_W);
  assign s_axi.wready  = en_q && (wstate == ST_IDLE || wstate == ST_HAVE_AW);
  assign s_axi.bvalid  = (wstate == ST_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = en_q && (!rvalid_q || s_axi.rready);
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign led = led_q;
  assign irq = irq_q;

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid && s_axi.wready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;

  // Write commits on the edge that completes the second of the AW/W handshakes.
  assign wr_go     = (aw_hs || wstate == ST_HAVE_AW) && (w_hs || wstate == ST_HAVE_W);
  assign wr_addr   = (wstate == ST_HAVE_AW) ? aw_addr_q : s_axi.awaddr;
  assign wr_data   = (wstate == ST_HAVE_W) ? w_data_q : s_axi.wdata;
  assign wr_strb   = (wstate == ST_HAVE_W) ? w_strb_q : s_axi.wstrb;
  assign wr_mapped = (wr_addr[ALEN-1:4] == '0);
  assign lane_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
  assign edge_clr  = (wr_go && wr_mapped && wr_addr[3:2] == 2'd3) ?
                     (wr_data[NUM_BTN-1:0] & lane_mask[NUM_BTN-1:0]) : '0;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wstate    <= ST_IDLE;
      en_q      <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
      led_q     <= '0;
    end else begin
      en_q <= 1'b1;
      if (wr_go) begin
        wstate  <= ST_RESP;
        bresp_q <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
        if (wr_mapped && wr_addr[3:2] == 2'd0)
          led_q <= (led_q & ~lane_mask[NUM_LED-1:0]) | (wr_data[NUM_LED-1:0] & lane_mask[NUM_LED-1:0]);
      end else begin
        case (wstate)
          ST_IDLE: begin
            if (aw_hs) begin
              wstate    <= ST_HAVE_AW;
              aw_addr_q <= s_axi.awaddr;
            end else if (w_hs) begin
              wstate   <= ST_HAVE_W;
              w_data_q <= s_axi.wdata;
              w_strb_q <= s_axi.wstrb;
            end
          end
          ST_RESP: if (s_axi.bready) wstate <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

  assign rd_mapped = (s_axi.araddr[ALEN-1:4] == '0);

  always_comb begin
    rd_word = '0;
    case (s_axi.araddr[3:2])
      2'd0: rd_word[NUM_LED-1:0] = led_q;
      2'd1: rd_word[NUM_SW-1:0]  = sw_c;
      2'd2: rd_word[NUM_BTN-1:0] = btn_c;
      default: rd_word[NUM_BTN-1:0] = edge_q;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mapped ? rd_word : '0;
      rresp_q  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn, sw};
      sync2 <= sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  logic [CW-1:0] db_cnt [NI];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cond <= '0;
      for (int unsigned i = 0; i < NI; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NI; i++) begin
        if (sync2[i] == cond[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
          cond[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign cond = sync2;
`endif

  assign sw_c  = cond[NUM_SW-1:0];
  assign btn_c = cond[NI-1:NUM_SW];

  // A new rising edge wins over a simultaneous write-1-to-clear.
  assign edge_next = (edge_q & ~edge_clr) | (btn_c & ~btn_prev);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      btn_prev <= '0;
      edge_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      btn_prev <= btn_c;
      edge_q   <= edge_next;
      irq_q    <= |edge_next;
    end
  end

endmodule
